neuron_mac: RTL
===============

// Module: neuron_mac
// PURPOSE
//  Parametrised fixed-point neuron for the layer array: streams numWeight inputs, multiplies each by a stored weight,
//  accumulates with saturation, adds a loadable bias and emits one activated result per input vector.
//  Weights/bias are loaded over the shared config bus, addressed by layer/neuron number; one instance per neuron.
// PARAMETERS
//  layerNo        0     layer index this neuron answers to on the config bus
//  neuronNo       0     neuron index within layer
//  numWeight      10    weights (= inputs) per vector, >=2
//  dataWidth      16    signed input/weight/output width (two's complement)
//  weightIntWidth 1     integer bits of input/weight format (incl. sign); frac = dataWidth-weightIntWidth
// PORTS
//  clk               in   1          clock, all logic on rising edge
//  rst               in   1          synchronous, active-high reset
//  myInput           in   dataWidth  signed input sample
//  myInputValid      in   1          myInput valid this cycle
//  weightValid       in   1          weightValue valid
//  biasValid         in   1          biasValue valid
//  weightValue       in   32         weight in [dataWidth-1:0], upper bits ignored
//  biasValue         in   32         bias in product scale (2*frac frac bits), sign-extended to 2*dataWidth
//  config_layer_num  in   32         target layer of current load
//  config_neuron_num in   32         target neuron of current load
//  out               out  dataWidth  activated result
//  outvalid          out  1          one-cycle pulse, out valid
// BEHAVIOUR
//  Reset: out=0, outvalid=0, w_addr=0, r_addr=0, acc=0, bias=0, pipeline valids=0. Weight RAM not cleared.
//  Match = (config_layer_num==layerNo)&&(config_neuron_num==neuronNo); no match -> load ignored.
//  Weight load: weightValid&match writes RAM[w_addr], w_addr++; wraps numWeight-1 -> 0 (reload overwrites in order).
//  Bias load: biasValid&match -> bias reg, effective next cycle; may coincide with weight load.
//  Pipeline (input accepted at cycle T, myInputValid may be high every cycle, no backpressure):
//   T: RAM read at r_addr, input registered; r_addr++, wraps numWeight-1 -> 0.
//   T+1: mul = signed input*weight, 2*dataWidth bits, registered.
//   T+2: acc = sat(acc+mul); first element of vector loads acc=mul (no clear bubble).
//   T+3 (last element only): s = sat(acc+bias).
//   T+4: out = act(scale(s)), outvalid=1 for exactly one cycle.
//  Latency last input -> outvalid: 4 cycles; back-to-back vectors sustain 1 input/cycle.
//  Saturation: add computed at 2*dataWidth+1 bits; overflow clamps to max/min signed 2*dataWidth.
//  scale(s): bits [2*dataWidth-1-weightIntWidth -: dataWidth]; if dropped high bits are not sign copies,
//   clamp to 0x7FF..F / 0x800..0 (dataWidth bits).
//  Simultaneous weight write and read of same address: read returns old data (read-first).
//  Loading while vectors stream is legal but result of that vector is undefined; no error flag.
//  rst mid-vector: partial vector discarded, in-flight outvalid suppressed, next input is element 0.
// CONFIGURATION
//  NEURON_RELU_EN defined: act(x) = (x<0) ? 0 : x (ReLU).
//  NEURON_RELU_EN undefined: act(x) = x (linear, for final layer); latency unchanged either way.
// TESTING (numWeight=4, dataWidth=16, weightIntWidth=1, Q1.15)
//  1 Load weights 0x4000 x4, bias 0; inputs 0x2000 x4 -> out=0x4000, outvalid 4 cycles after 4th input.
//  2 As 1 with biasValue=0x0800_0000 -> out=0x5000; bias load with wrong neuron no. -> out stays 0x4000.
//  3 Weight load with config_neuron_num!=neuronNo -> RAM unchanged; 5 matched loads -> addr 0 overwritten.
//  4 Weights 0x7FFF, inputs 0x7FFF, bias 0x7FFF_FFFF -> acc/bias saturate, out=0x7FFF.
//  5 Weights 0x4000, inputs 0xE000 -> out=0x0000 with NEURON_RELU_EN, 0xC000 without.
//  6 2 inputs, rst 1 cycle, then 4 inputs 0x2000 (weights as 1) -> single outvalid, out=0x4000; reset values checked.

Source files
------------

// File: rtl/neuron_mac.sv
// Fixed-point neuron: streams numWeight inputs against stored weights, saturating MAC, bias, activation.
// Define NEURON_RELU_EN for a ReLU output stage; otherwise the output is linear.
module neuron_mac #(
  parameter int layerNo        = 0,
  parameter int neuronNo       = 0,
  parameter int numWeight      = 10,
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] myInput,
  input  logic                 myInputValid,
  input  logic                 weightValid,
  input  logic                 biasValid,
  input  logic [31:0]          weightValue,
  input  logic [31:0]          biasValue,
  input  logic [31:0]          config_layer_num,
  input  logic [31:0]          config_neuron_num,
  output logic [dataWidth-1:0] out,
  output logic                 outvalid
);

  localparam int AW = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam int PW = 2 * dataWidth;
  localparam logic [AW-1:0] LAST = AW'(numWeight - 1);

  logic signed [dataWidth-1:0] ram [numWeight];
  logic [AW-1:0]               w_addr, r_addr;
  logic                        match;

  logic signed [dataWidth-1:0] in_r, w_rd;
  logic signed [PW-1:0]        mul, acc, bias, s;
  logic                        v0, v1, v2, v3;
  logic                        first0, last0, first1, last1;

  logic [weightIntWidth:0]     top_bits;
  logic [dataWidth-1:0]        scaled, activated;

  assign match = (config_layer_num == 32'(layerNo)) && (config_neuron_num == 32'(neuronNo));

  function automatic logic signed [PW-1:0] sat_add(input logic signed [PW-1:0] a,
                                                   input logic signed [PW-1:0] b);
    logic signed [PW:0] sum;
    sum = {a[PW-1], a} + {b[PW-1], b};
    if (sum[PW] != sum[PW-1])
      sat_add = sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    else
      sat_add = sum[PW-1:0];
  endfunction

  // Weight RAM is never cleared; the pipeline read below sees the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (weightValid && match)
      ram[w_addr] <= weightValue[dataWidth-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr   <= '0;
      r_addr   <= '0;
      bias     <= '0;
      acc      <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      out      <= '0;
      outvalid <= 1'b0;
    end else begin
      if (weightValid && match)
        w_addr <= (w_addr == LAST) ? '0 : w_addr + 1'b1;
      if (biasValid && match)
        bias <= PW'($signed(biasValue));

      v0 <= myInputValid;
      if (myInputValid) begin
        in_r   <= myInput;
        w_rd   <= ram[r_addr];
        first0 <= (r_addr == '0);
        last0  <= (r_addr == LAST);
        r_addr <= (r_addr == LAST) ? '0 : r_addr + 1'b1;
      end

      v1     <= v0;
      first1 <= first0;
      last1  <= last0;
      if (v0)
        mul <= PW'(in_r) * PW'(w_rd);

      // The first element overwrites acc, so consecutive vectors need no clear cycle.
      v2 <= v1 && last1;
      if (v1)
        acc <= first1 ? mul : sat_add(acc, mul);

      v3 <= v2;
      if (v2)
        s <= sat_add(acc, bias);

      outvalid <= v3;
      if (v3)
        out <= activated;
    end
  end

  // Dropped integer bits must all copy the sign of the kept window, else clamp.
  always_comb begin
    top_bits = s[PW-1 -: weightIntWidth+1];
    scaled   = s[PW-1-weightIntWidth -: dataWidth];
    if (!((top_bits == '0) || (top_bits == '1)))
      scaled = s[PW-1] ? {1'b1, {(dataWidth-1){1'b0}}} : {1'b0, {(dataWidth-1){1'b1}}};
`ifdef NEURON_RELU_EN
    activated = scaled[dataWidth-1] ? '0 : scaled;
`else
    activated = scaled;
`endif
  end

endmodule
